// File: rtl/spi_slave_physical_if.sv
// Host- and pin-side signal bundle for spi_slave_physical.
// Status ports exist only when SPI_SLAVE_STATUS_EN is defined.
interface spi_slave_physical_if;
  logic       cpol;
  logic       cpha;
  logic       msb_first;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       spi_miso;
  logic       spi_miso_oe;
`ifdef SPI_SLAVE_STATUS_EN
  logic       rx_overrun;
  logic       tx_underrun;
  logic       status_clr;
`endif

  modport slave (
    input  cpol, cpha, msb_first, tx_data, tx_valid, rx_ready,
           spi_clk, spi_mosi, spi_cs_n,
    output tx_ready, rx_data, rx_valid, busy, spi_miso, spi_miso_oe
`ifdef SPI_SLAVE_STATUS_EN
    , output rx_overrun, tx_underrun, input status_clr
`endif
  );

  modport master (
    output cpol, cpha, msb_first, tx_data, tx_valid, rx_ready,
           spi_clk, spi_mosi, spi_cs_n,
    input  tx_ready, rx_data, rx_valid, busy, spi_miso, spi_miso_oe
`ifdef SPI_SLAVE_STATUS_EN
    , input rx_overrun, tx_underrun, output status_clr
`endif
  );
endinterface

// File: rtl/spi_slave_physical.sv
// SPI target physical layer: oversampled sclk/mosi/cs_n, byte deserialiser and MISO serialiser.
// Optional sticky rx_overrun/tx_underrun status enabled by defining SPI_SLAVE_STATUS_EN.
module spi_slave_physical #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  TX_IDLE     = 8'hFF
) (
  input logic                  clk,
  input logic                  nrst,
  spi_slave_physical_if.slave  bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic       sclk_d, cs_d;
  logic       sclk_s, mosi_s, cs_s;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic       lead_edge, trail_edge, sample_edge, drive_edge;
  logic       enter, leave, do_sample, do_drive;
  logic       cpol_q, cpha_q, msb_q;
  logic [7:0] tx_sr, rx_sr, rx_next, tx_buf, load_byte;
  logic       tx_full, load_pend, load, byte_done;
  logic [2:0] bit_cnt;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;

  // cs_n chain resets low so a select already asserted at reset release is
  // not mistaken for a fresh fall; a transfer needs a real cs_n falling edge.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign cs_rise     = cs_s & ~cs_d;
  assign cs_fall     = ~cs_s & cs_d;
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign drive_edge  = cpha_q ? lead_edge : trail_edge;

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    enter     = 1'b0;
    leave     = 1'b0;
    do_sample = 1'b0;
    do_drive  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          enter   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          leave   = 1'b1;
        end else begin
          do_sample = sample_edge;
          do_drive  = drive_edge;
        end
      end
    endcase
  end

  assign rx_next   = msb_q ? {rx_sr[6:0], mosi_s} : {mosi_s, rx_sr[7:1]};
  assign byte_done = do_sample & (bit_cnt == 3'd7);
  assign load_byte = tx_full ? tx_buf : TX_IDLE;
  // A drive edge at bit_cnt 0 is the first bit of a byte: reload only when a
  // byte just completed; the first CPHA=1 byte already sits in tx_sr from entry.
  assign load      = enter | (do_drive & load_pend);

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      msb_q      <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      load_pend  <= 1'b0;
      tx_buf     <= '0;
      tx_full    <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      if (enter) begin
        cpol_q <= bus.cpol;
        cpha_q <= bus.cpha;
        msb_q  <= bus.msb_first;
      end
      if (enter || leave) begin
        bit_cnt   <= '0;
        rx_sr     <= '0;
        load_pend <= 1'b0;
      end else if (do_sample) begin
        rx_sr   <= rx_next;
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          rx_data_q <= rx_next;
          load_pend <= 1'b1;
        end
      end else if (do_drive && load_pend) begin
        load_pend <= 1'b0;
      end

      if (load) begin
        tx_sr <= load_byte;
      end else if (do_drive && bit_cnt != 3'd0) begin
        tx_sr <= msb_q ? {tx_sr[6:0], 1'b0} : {1'b0, tx_sr[7:1]};
      end

      if (bus.tx_valid && !tx_full) begin
        tx_buf  <= bus.tx_data;
        tx_full <= 1'b1;
      end else if (load) begin
        tx_full <= 1'b0;
      end

      if (byte_done)                      rx_valid_q <= 1'b1;
      else if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_STATUS_EN
  logic rx_overrun_q, tx_underrun_q;

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      if (byte_done && rx_valid_q && !bus.rx_ready) rx_overrun_q <= 1'b1;
      else if (bus.status_clr)                      rx_overrun_q <= 1'b0;
      if (load && !tx_full)         tx_underrun_q <= 1'b1;
      else if (bus.status_clr)      tx_underrun_q <= 1'b0;
    end
  end

  assign bus.rx_overrun  = rx_overrun_q;
  assign bus.tx_underrun = tx_underrun_q;
`endif

  assign bus.tx_ready    = ~tx_full;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.busy        = (state_q == ACTIVE);
  assign bus.spi_miso_oe = (state_q == ACTIVE);
  assign bus.spi_miso    = (state_q == ACTIVE) & (msb_q ? tx_sr[7] : tx_sr[0]);

endmodule

// File: tb/tb_spi_slave_physical.sv
// Self-checking bench for spi_slave_physical: bit-banged SPI master, host feeder/monitor
// and a byte-level reference model (expected rx bytes, MISO bytes, sticky status).
`timescale 1ns/1ps
module tb_spi_slave_physical;
  localparam int         H         = 6;
  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  spi_slave_physical_if bus();

  spi_slave_physical #(.SYNC_STAGES(2), .TX_IDLE(IDLE_BYTE)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] txq[$];
  logic [7:0] mo_q[$];
  logic [7:0] tl_q[$];
  logic [7:0] m_rx[$];
  logic [7:0] got_rx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] pend_byte;
  bit         pend_valid = 1'b0;
  bit         m_und = 1'b0;
  bit         m_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tx_ready"}, bus.tx_ready, 1'b1);
    check({tag, "_rx_data"},  bus.rx_data, 8'h00);
    check({tag, "_rx_valid"}, bus.rx_valid, 1'b0);
    check({tag, "_busy"},     bus.busy, 1'b0);
    check({tag, "_miso"},     bus.spi_miso, 1'b0);
    check({tag, "_miso_oe"},  bus.spi_miso_oe, 1'b0);
`ifdef SPI_SLAVE_STATUS_EN
    check({tag, "_ovr"}, bus.rx_overrun, 1'b0);
    check({tag, "_und"}, bus.tx_underrun, 1'b0);
`endif
  endtask

  task automatic check_rx(input string tag);
    int n;
    check({tag, "_rx_count"}, got_rx.size(), exp_rx.size());
    n = (got_rx.size() < exp_rx.size()) ? got_rx.size() : exp_rx.size();
    for (int k = 0; k < n; k++) check({tag, "_rx_byte"}, got_rx[k], exp_rx[k]);
    got_rx.delete();
    exp_rx.delete();
  endtask

  task automatic check_status(input string tag);
`ifdef SPI_SLAVE_STATUS_EN
    check({tag, "_tx_underrun"}, bus.tx_underrun, m_und);
    check({tag, "_rx_overrun"},  bus.rx_overrun, m_ovr);
`endif
  endtask

  task automatic clear_status(input string tag);
`ifdef SPI_SLAVE_STATUS_EN
    bus.status_clr = 1'b1;
    wait_clk(1);
    bus.status_clr = 1'b0;
    wait_clk(1);
    m_und = 1'b0;
    m_ovr = 1'b0;
    check_status(tag);
`endif
  endtask

  // Host side: offer queued tx bytes one at a time; pop once accepted.
  initial begin
    bit rdy_last = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.tx_valid && rdy_last) begin
        void'(txq.pop_front());
        bus.tx_valid = 1'b0;
      end
      if (!bus.tx_valid && txq.size() > 0) begin
        bus.tx_data  = txq[0];
        bus.tx_valid = 1'b1;
      end
      rdy_last = bus.tx_ready;
    end
  end

  // Host side: record every consumed rx byte.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) got_rx.push_back(bus.rx_data);
    end
  end

  // One SPI master transfer of mo_q, host preloads tl_q. stop_bits>0 cuts it short.
  task automatic xfer(input string tag, input bit pol, input bit pha, input bit msb,
                      input int stop_bits, input bit do_rst);
    int         nbits, stop, c, s, loads, t, bi;
    logic [7:0] rcv, exp_b;
    logic       mb, miso_bit;
    nbits = mo_q.size() * 8;
    stop  = (stop_bits > 0) ? stop_bits : nbits;
    bus.cpol = pol; bus.cpha = pha; bus.msb_first = msb; bus.spi_clk = pol;
    foreach (tl_q[i]) txq.push_back(tl_q[i]);
    if (tl_q.size() > 0) begin
      t = 0;
      while (bus.tx_ready && t < 200) begin @(negedge clk); t++; end
      check({tag, "_preload"}, bus.tx_ready, 1'b0);
    end
    wait_clk(2 * H);
    bus.spi_cs_n = 1'b0;
    wait_clk(2 * H);
    check({tag, "_busy_on"}, bus.busy, 1'b1);
    check({tag, "_oe_on"}, bus.spi_miso_oe, 1'b1);
    m_rx.delete();
    rcv = '0;
    for (int i = 0; i < stop; i++) begin
      bi = msb ? 7 - (i % 8) : (i % 8);
      exp_b = mo_q[i / 8];
      mb = exp_b[bi];
      if (!pha) begin
        bus.spi_mosi = mb;
        wait_clk(H);
        miso_bit = bus.spi_miso;
        bus.spi_clk = ~pol;
        wait_clk(H);
        bus.spi_clk = pol;
      end else begin
        bus.spi_clk = ~pol;
        bus.spi_mosi = mb;
        wait_clk(H);
        miso_bit = bus.spi_miso;
        bus.spi_clk = pol;
        wait_clk(H);
      end
      rcv[bi] = miso_bit;
      if (i % 8 == 7) m_rx.push_back(rcv);
    end
    wait_clk(H);

    c = stop / 8;
    s = (stop + 7) / 8;
    for (int k = 0; k < c; k++) begin
      exp_b = (k < tl_q.size()) ? tl_q[k] : IDLE_BYTE;
      check({tag, "_miso_byte"}, m_rx[k], exp_b);
      if (bus.rx_ready) exp_rx.push_back(mo_q[k]);
      else begin
        if (pend_valid) m_ovr = 1'b1;
        pend_byte  = mo_q[k];
        pend_valid = 1'b1;
      end
    end
    loads = pha ? s : 1 + c;
    if (loads > tl_q.size()) m_und = 1'b1;

    if (do_rst) begin
      nrst = 1'b1;
      wait_clk(1);
      check_reset({tag, "_midrst"});
      nrst = 1'b0;
      wait_clk(2 * H);
      check({tag, "_busy_cs_low_after_rst"}, bus.busy, 1'b0);
      m_und = 1'b0; m_ovr = 1'b0; pend_valid = 1'b0;
    end
    bus.spi_cs_n = 1'b1;
    wait_clk(2 * H);
    check({tag, "_busy_off"}, bus.busy, 1'b0);
    check({tag, "_oe_off"}, bus.spi_miso_oe, 1'b0);
    check_rx(tag);
    check_status(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n, nt;
    bit         p0, p1, p2;
    nrst = 1'b1;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.msb_first = 1'b1;
    bus.rx_ready = 1'b1;
    bus.spi_clk = 1'b0; bus.spi_mosi = 1'b0; bus.spi_cs_n = 1'b1;
`ifdef SPI_SLAVE_STATUS_EN
    bus.status_clr = 1'b0;
`endif
    wait_clk(3);
    check_reset("rst_hold");
    nrst = 1'b0;
    wait_clk(2 * H);
    check_reset("rst_release");

    // Mode 0 MSB-first, A5 in, 3C out.
    mo_q = '{8'hA5}; tl_q = '{8'h3C};
    xfer("t1", 1'b0, 1'b0, 1'b1, 0, 1'b0);
    clear_status("t1_clr");

    // Mode 3 LSB-first, four back-to-back bytes.
    mo_q = '{8'h01, 8'h80, 8'hFF, 8'h00}; tl_q = '{8'hC3, 8'h5A, 8'h0F, 8'hE1};
    xfer("t2", 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Underrun: nothing offered, two bytes.
    mo_q = '{8'h12, 8'h34}; tl_q.delete();
    xfer("t3", 1'b0, 1'b1, 1'b1, 0, 1'b0);
    clear_status("t3_clr");

    // Overrun: rx_ready held low across two bytes.
    bus.rx_ready = 1'b0;
    mo_q = '{8'h11, 8'h22}; tl_q = '{8'h66, 8'h77};
    xfer("t4", 1'b0, 1'b0, 1'b1, 0, 1'b0);
    check("t4_rx_data", bus.rx_data, 8'h22);
    check("t4_rx_valid", bus.rx_valid, 1'b1);
    bus.rx_ready = 1'b1;
    exp_rx.push_back(pend_byte);
    pend_valid = 1'b0;
    wait_clk(3);
    check("t4_rx_valid_consumed", bus.rx_valid, 1'b0);
    check_rx("t4_consume");
    clear_status("t4_clr");

    // Mode 1 abort after 5 bits, then a full byte.
    mo_q = '{8'hF0}; tl_q.delete();
    xfer("t5a", 1'b0, 1'b1, 1'b1, 5, 1'b0);
    check("t5a_no_rx_valid", bus.rx_valid, 1'b0);
    mo_q = '{8'h5A}; tl_q = '{8'h96};
    xfer("t5b", 1'b0, 1'b1, 1'b1, 0, 1'b0);
    clear_status("t5_clr");

    // Mode 2 reset mid-byte, then a full byte.
    mo_q = '{8'h3E}; tl_q.delete();
    xfer("t6a", 1'b1, 1'b0, 1'b1, 4, 1'b1);
    mo_q = '{8'hC3}; tl_q = '{8'h81};
    xfer("t6b", 1'b1, 1'b0, 1'b1, 0, 1'b0);
    clear_status("t6_clr");

    // Randomized transfers.
    for (int it = 0; it < 20; it++) begin
      n  = $urandom_range(1, 4);
      nt = $urandom_range(0, n);
      mo_q.delete(); tl_q.delete();
      for (int k = 0; k < n; k++)  mo_q.push_back(8'($urandom));
      for (int k = 0; k < nt; k++) tl_q.push_back(8'($urandom));
      p0 = 1'($urandom_range(0, 1));
      p1 = 1'($urandom_range(0, 1));
      p2 = 1'($urandom_range(0, 1));
      xfer("rnd", p0, p1, p2, 0, 1'b0);
      if ($urandom_range(0, 3) == 0) clear_status("rnd_clr");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
